uart_rx: RTL and testbench

- UART receiver; the receive-side counterpart to the 16x-oversampling baud tick generator.
- Consumes the generator's one-cycle 16x tick and the asynchronous serial line.
- Recovers LSB-first frames by mid-bit sampling.
- Presents bytes on a valid/ready interface to the core, with framing and overrun error flags.

---
 rtl/uart_rx_if.sv | 49 ++++
 rtl/uart_rx.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Receive-side handshake bundle between uart_rx and its consumer.
//
// Signals:
//   rx_data      received word, LSB = first data bit on the line
//   rx_valid     rx_data holds an unconsumed word
//   rx_ready     consumer accepts rx_data this cycle
//   frame_err    one-cycle pulse: a stop bit was sampled low
//   overrun_err  one-cycle pulse: a completed frame was dropped
//   parity_err   one-cycle pulse: parity mismatch (only with UART_RX_PARITY_EN)
//
// Modports: master = receiver side (uart_rx), slave = consumer side.
// Optional feature macro: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver driven by a one-cycle 16x oversample tick. Recovers LSB-first
// frames by mid-bit sampling and presents bytes on a valid/ready interface with
// framing and overrun error pulses.
//
// Ports:
//   clk         system clock
//   arst_n      asynchronous, active-low reset
//   tick        16x oversample strobe, one clk wide
//   rx_in       asynchronous serial line, idles high
//   parity_odd  1 = odd parity, 0 = even (only with UART_RX_PARITY_EN)
//   busy        high in every state except IDLE
//   bus         uart_rx_if.master: rx_data/rx_valid/rx_ready/frame_err/
//               overrun_err (+ parity_err with UART_RX_PARITY_EN)
//
// Parameters: DATA_BITS (5..9), STOP_BITS (1..2), SYNC_STAGES (>=2).
// The bus interface must be instantiated with the same DATA_BITS.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      arst_n,
    input  logic      tick,
    input  logic      rx_in,
`ifdef UART_RX_PARITY_EN
    input  logic      parity_odd,
`endif
    output logic      busy,
    uart_rx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [3:0] LP_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LP_LAST_STOP = 4'(STOP_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [3:0]             r_os_cnt;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_stop_bad;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_ovr;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   r_perr;
`endif

    logic w_rxs;
    logic w_os_mid;
    logic w_os_end;
    logic w_last_stop;
    logic w_stop_bad;
    logic w_par_bad;
    logic w_word_ok;

    always_comb begin
        w_rxs       = r_sync[SYNC_STAGES-1];
        w_os_mid    = (r_os_cnt == 4'd7);
        w_os_end    = (r_os_cnt == 4'd15);
        w_last_stop = (r_bit_cnt == LP_LAST_STOP);
        // Includes the stop sample being taken this cycle.
        w_stop_bad  = r_stop_bad | ~w_rxs;
`ifdef UART_RX_PARITY_EN
        // Expected parity bit is ^data for even, ~^data for odd.
        w_par_bad   = r_par_bit ^ (^r_shift) ^ parity_odd;
`else
        w_par_bad   = 1'b0;
`endif
        w_word_ok   = ~w_stop_bad & ~w_par_bad;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sync     <= '1;
            r_state    <= S_IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_stop_bad <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr <= 1'b0;
`endif
            // Transfer clears valid; a frame completing this cycle re-sets it below.
            if (r_valid && bus.rx_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (w_os_mid) begin
                            if (!w_rxs) begin
                                r_state   <= S_DATA;
                                r_os_cnt  <= '0;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (w_os_end) begin
                            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == LP_LAST_DATA) begin
                                r_bit_cnt  <= '0;
                                r_stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                r_state    <= S_PARITY;
`else
                                r_state    <= S_STOP;
`endif
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (w_os_end) begin
                            r_par_bit <= w_rxs;
                            r_state   <= S_STOP;
                        end
                    end
                end
`endif

                S_STOP: begin
                    if (tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                        if (w_os_end) begin
                            r_stop_bad <= w_stop_bad;
                            if (w_last_stop) begin
                                // Leave at mid-bit so a back-to-back start edge is seen.
                                r_state   <= S_IDLE;
                                r_bit_cnt <= '0;
                                r_ferr    <= w_stop_bad;
`ifdef UART_RX_PARITY_EN
                                r_perr    <= w_par_bad;
`endif
                                if (w_word_ok) begin
                                    if (!r_valid || bus.rx_ready) begin
                                        r_data  <= r_shift;
                                        r_valid <= 1'b1;
                                    end else begin
                                        r_ovr <= 1'b1;
                                    end
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_err   = r_ferr;
    assign bus.overrun_err = r_ovr;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares whenever a new word is presented, and
// counts error-flag cycles for comparison at checkpoints.
// Optional feature macro: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PAR_BITS  = 1;
`else
    localparam int unsigned PAR_BITS  = 0;
`endif
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    // Cycles from driving the start edge to rx_valid with tick every cycle:
    // 2 sync flops + 1 detect cycle + 8 ticks to mid start + 16 per later bit.
    localparam int LATENCY = 2 + 1 + 8 + 16 * (FRAME_BITS - 1);

    logic clk;
    logic arst_n;
    logic tick;
    logic rx_in;
    logic parity_odd;
    logic busy;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) bus_if ();

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .tick      (tick),
        .rx_in     (rx_in),
`ifdef UART_RX_PARITY_EN
        .parity_odd(parity_odd),
`endif
        .busy      (busy),
        .bus       (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int tick_div = 1;
    int start_cyc = 0;
    int last_present_cyc = 0;
    int n_present = 0;
    int n_valid_cyc = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_perr = 0;
    logic [DATA_BITS-1:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick strobe: high one cycle out of every tick_div cycles.
    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
            tick = (tcnt == 0);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a word is newly presented when valid is high and the previous
    // cycle was either empty or a transfer.
    initial begin
        logic prev_v, prev_r;
        logic [DATA_BITS-1:0] prev_d, e;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end else begin
                if (bus_if.rx_valid && !(prev_v && !prev_r)) begin
                    n_present++;
                    last_present_cyc = cyc;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_word: got 0x%0h, required no word", bus_if.rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus_if.rx_data !== e) begin
                            n_errors++;
                            $display("FAIL rx_data: got 0x%0h, required 0x%0h", bus_if.rx_data, e);
                        end
                    end
                end else if (bus_if.rx_valid && prev_v && !prev_r) begin
                    n_checks++;
                    if (bus_if.rx_data !== prev_d) begin
                        n_errors++;
                        $display("FAIL data_stable: got 0x%0h, required 0x%0h", bus_if.rx_data, prev_d);
                    end
                end
                if (bus_if.rx_valid)    n_valid_cyc++;
                if (bus_if.frame_err)   n_ferr++;
                if (bus_if.overrun_err) n_ovr++;
`ifdef UART_RX_PARITY_EN
                if (bus_if.parity_err)  n_perr++;
`endif
                prev_v = bus_if.rx_valid;
                prev_r = bus_if.rx_ready;
                prev_d = bus_if.rx_data;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // par_mode: -1 = correct parity for parity_odd, 0/1 = forced parity bit.
    // rdy_at: cycle offset at which rx_ready is pulsed for one cycle (-1 = none).
    // stop_at: cycle offset at which to abandon the frame (-1 = send it all).
    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic stop_v,
                              input int par_mode, input int rdy_at, input int stop_at);
        logic [15:0] bits;
        int o;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < int'(DATA_BITS); i++) bits[1 + i] = d[i];
        if (PAR_BITS == 1) begin
            bits[1 + DATA_BITS] = (par_mode < 0) ? ((^d) ^ parity_odd) : par_mode[0];
        end
        for (int s = 0; s < int'(STOP_BITS); s++) bits[1 + DATA_BITS + PAR_BITS + s] = stop_v;
        for (int b = 0; b < int'(FRAME_BITS); b++) begin
            for (int c = 0; c < 16 * tick_div; c++) begin
                @(posedge clk);
                #1;
                o = b * 16 * tick_div + c;
                if (o == stop_at) return;
                if (o == 0) start_cyc = cyc;
                if (c == 0) rx_in = bits[b];
                if (rdy_at >= 0) begin
                    if (o == rdy_at) bus_if.rx_ready = 1'b1;
                    else if (o == rdy_at + 1) bus_if.rx_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int p0, v0, f0, o0, q0, s0;
        arst_n = 1'b0;
        rx_in = 1'b1;
        parity_odd = 1'b0;
        bus_if.rx_ready = 1'b0;
        idle(3);
        @(negedge clk);
        check("reset_rx_data", bus_if.rx_data, 0);
        check("reset_rx_valid", bus_if.rx_valid, 0);
        check("reset_frame_err", bus_if.frame_err, 0);
        check("reset_overrun_err", bus_if.overrun_err, 0);
        check("reset_busy", busy, 0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        idle(5);

        // 0xA5, always ready: one-cycle valid at the expected latency.
        bus_if.rx_ready = 1'b1;
        v0 = n_valid_cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, -1, -1);
        idle(20);
        check("a5_latency", last_present_cyc - start_cyc, LATENCY);
        check("a5_valid_cycles", n_valid_cyc - v0, 1);
        check("a5_present", n_present, 1);

        // Glitch: 4 low cycles then high; START rejects at its 8th tick.
        p0 = n_present;
        rx_in = 1'b0;
        idle(4);
        rx_in = 1'b1;
        idle(6);
        @(negedge clk);
        check("glitch_busy_before_8th_tick", busy, 1);
        idle(1);
        @(negedge clk);
        check("glitch_busy_after_8th_tick", busy, 0);
        idle(20);
        check("glitch_no_word", n_present - p0, 0);
        check("glitch_no_ferr", n_ferr, 0);

        // Bad stop bit on 0x3C, then a good 0x55.
        p0 = n_present;
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1, -1, -1);
        rx_in = 1'b1;
        idle(30);
        check("ferr_pulse_count", n_ferr - f0, 1);
        check("ferr_no_word", n_present - p0, 0);
        check("ferr_valid_low", bus_if.rx_valid, 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1, -1, -1);
        idle(20);
        check("after_ferr_present", n_present - p0, 1);

        // Back-to-back 0x11, 0x22 with no consumer: 0x22 overruns.
        bus_if.rx_ready = 1'b0;
        o0 = n_ovr;
        f0 = n_ferr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1, -1);
        idle(20);
        @(negedge clk);
        check("ovr_pulse_count", n_ovr - o0, 1);
        check("ovr_no_ferr", n_ferr - f0, 0);
        check("ovr_valid_held", bus_if.rx_valid, 1);
        check("ovr_data_kept", bus_if.rx_data, 8'h11);
        @(posedge clk);
        #1;
        bus_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_drained", bus_if.rx_valid, 0);

        // Same, but ready pulsed exactly in frame 2's completion cycle.
        o0 = n_ovr;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1, -1, -1, -1);
        send_frame(8'h22, 1'b1, -1, LATENCY - 1, -1);
        idle(20);
        @(negedge clk);
        check("swap_no_ovr", n_ovr - o0, 0);
        check("swap_valid", bus_if.rx_valid, 1);
        check("swap_data", bus_if.rx_data, 8'h22);
        @(posedge clk);
        #1;
        bus_if.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_ready = 1'b0;
        @(negedge clk);
        check("swap_drained", bus_if.rx_valid, 0);

        // Reset in data bit 4 while a word is held, then a fresh 0x81.
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, -1, -1, -1);
        idle(5);
        @(negedge clk);
        check("pre_reset_valid", bus_if.rx_valid, 1);
        f0 = n_ferr;
        o0 = n_ovr;
        q0 = n_perr;
        send_frame(8'hF0, 1'b1, -1, -1, 5 * 16 + 8);
        arst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("midreset_rx_data", bus_if.rx_data, 0);
        check("midreset_rx_valid", bus_if.rx_valid, 0);
        check("midreset_busy", busy, 0);
        idle(3);
        arst_n = 1'b1;
        idle(5);
        bus_if.rx_ready = 1'b1;
        p0 = n_present;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, -1, -1);
        idle(20);
        check("post_reset_present", n_present - p0, 1);
        check("post_reset_no_flags", (n_ferr - f0) + (n_ovr - o0) + (n_perr - q0), 0);

        // Sparse tick: one tick every 3 cycles.
        tick_div = 3;
        idle(3);
        p0 = n_present;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, -1, -1);
        idle(60);
        tick_div = 1;
        idle(3);
        check("slow_tick_present", n_present - p0, 1);

`ifdef UART_RX_PARITY_EN
        // Odd parity on 0x03 requires parity bit 1.
        parity_odd = 1'b1;
        p0 = n_present;
        q0 = n_perr;
        send_frame(8'h03, 1'b1, 0, -1, -1);
        idle(30);
        check("perr_pulse_count", n_perr - q0, 1);
        check("perr_no_word", n_present - p0, 0);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1, -1, -1);
        idle(20);
        check("par_ok_present", n_present - p0, 1);
        check("par_ok_no_perr", n_perr - q0, 1);
        parity_odd = 1'b0;
`endif

        s0 = exp_q.size();
        check("scoreboard_empty", s0, 0);
        check("total_frame_err", n_ferr, 1);
        check("total_overrun_err", n_ovr, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
